// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle unsigned multiply/divide engine that feeds the hi/lo registers.
// A multiply uses a shift-add loop and a divide uses a restoring loop. Each
// loop runs one iteration per clock. While an operation is in flight, stall
// tells the control unit to freeze the PC and the register-file write enable.
//
// Optional feature, enabled when the macro MULDIV_EARLY_TERM_EN is defined:
//   A multiply finishes early once no multiplier bits are left unconsumed.
//   The accumulator is then aligned with a single barrel shift.
//   With the macro undefined, multiply latency is fixed and no shifter is built.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    request pulse, sampled only in IDLE
//   op       0 = multiply, 1 = divide (sampled with start)
//   a        multiplicand / dividend (rf read output 1)
//   b        multiplier / divisor (rf read output 2)
//   busy     high while a MUL or DIV iteration loop is running
//   stall    start in IDLE, or busy (combinational)
//   done     one-cycle pulse while hi/lo carry a fresh result
//   wehilo   hi/lo register write enable (same as done)
//   hi       product upper half, or remainder
//   lo       product lower half, or quotient
//   divzero  sticky flag set by a divide by zero, cleared by the next start
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             wehilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 divzero_q, divzero_d;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem_sh;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic                 early_done;
  logic [2*WIDTH-1:0]   acc_aligned;

  // One shift-add step. The sum is WIDTH+1 bits wide, so its carry becomes
  // the new top bit after the right shift.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step. The top bit of the difference is the borrow,
  // so it is clear exactly when the shifted remainder is >= the divisor.
  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};
  assign div_ge     = ~div_diff[WIDTH];
  assign div_next   = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // The low cnt_q bits of the accumulator still hold unconsumed multiplier
  // bits. If they are all zero, the remaining iterations would only shift.
`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask    = ~({WIDTH{1'b1}} << cnt_q);
  assign early_done  = (acc_q[WIDTH-1:0] & rem_mask) == {WIDTH{1'b0}};
  assign acc_aligned = acc_q >> cnt_q;
`else
  assign early_done  = 1'b0;
  assign acc_aligned = acc_q;
`endif

  // Next-state and datapath control. hi/lo are loaded on the edge that
  // enters FIN, so they are valid in the same cycle that done is high.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          divzero_d = 1'b0;
          cnt_d     = CNTW'(WIDTH);
          opnd_d    = op ? b : a;
          acc_d     = {{WIDTH{1'b0}}, (op ? a : b)};
          if (!op) begin
            state_d = MUL;
          end else if (b != {WIDTH{1'b0}}) begin
            state_d = DIV;
          end else begin
            state_d   = FIN;
            hi_d      = a;
            lo_d      = {WIDTH{1'b1}};
            divzero_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (early_done) begin
          state_d       = FIN;
          acc_d         = acc_aligned;
          {hi_d, lo_d}  = acc_aligned;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d      = FIN;
            {hi_d, lo_d} = mul_next;
          end
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d      = FIN;
          {hi_d, lo_d} = div_next;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. A reset during an operation abandons it
  // with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = (state_q == MUL) || (state_q == DIV);
  assign done    = (state_q == FIN);
  assign wehilo  = done;
  assign stall   = (start && (state_q == IDLE)) || busy;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed, table-driven bench for muldiv_sequencer (WIDTH = 16).
// A vector table covers multiply, divide and divide by zero. Hand-written
// sequences cover the cases that span several operations: start while busy,
// start during FIN, reset winning over start, and reset aborting a multiply.
// Expected multiply latency follows MULDIV_EARLY_TERM_EN when it is defined.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic        wehilo;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        divzero;

  int checks;
  int failures;

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  muldiv_sequencer #(.WIDTH(16), .CNTW(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .wehilo  (wehilo),
    .hi      (hi),
    .lo      (lo),
    .divzero (divzero)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any miss.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Cycles from the start cycle to done for a multiply with multiplier m.
  function automatic int mulLatency(input logic [15:0] m);
    int k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) k = i + 1;
    end
    if (EARLY) return (k + 2 > 17) ? 17 : k + 2;
    return 17;
  endfunction

  // Issue one start, scramble the operands afterwards, and wait (bounded)
  // for done. Returns the latency in cycles (0 on timeout) and the number
  // of cycles with stall high. The task returns in the done cycle.
  task automatic applyStimulus(input logic op_i, input logic [15:0] a_i,
                               input logic [15:0] b_i, output int latency,
                               output int stall_cycles);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    #1;
    stall_cycles = stall ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    op    = 1'($urandom);
    latency = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        latency = c;
        break;
      end
      if (stall) stall_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int stc;
    int exp_lat;
    int done_seen;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;

    //          op    a         b         hi        lo        dz
    vecs[0]  = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[2]  = '{1'b1, 16'd1000, 16'd7,    16'd6,    16'd142,  1'b0};
    vecs[3]  = '{1'b1, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0};
    vecs[4]  = '{1'b1, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1};
    vecs[5]  = '{1'b0, 16'h00FF, 16'h0003, 16'h0000, 16'h02FD, 1'b0};
    vecs[6]  = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 1'b0};
    vecs[8]  = '{1'b0, 16'hABCD, 16'h0001, 16'h0000, 16'hABCD, 1'b0};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
    vecs[10] = '{1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy",    32'(busy),    32'd0);
    checkOutput("reset_stall",   32'(stall),   32'd0);
    checkOutput("reset_done",    32'(done),    32'd0);
    checkOutput("reset_wehilo",  32'(wehilo),  32'd0);
    checkOutput("reset_hi",      32'(hi),      32'd0);
    checkOutput("reset_lo",      32'(lo),      32'd0);
    checkOutput("reset_divzero", 32'(divzero), 32'd0);

    // Reset and start together: reset wins, so nothing starts.
    reset = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h0003;
    b     = 16'h0003;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset_wins_busy", 32'(busy), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].op) exp_lat = (vecs[i].b == 16'h0000) ? 1 : 17;
      else            exp_lat = mulLatency(vecs[i].b);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, stc);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      checkOutput($sformatf("v%0d_stall_cycles", i), 32'(stc), 32'(exp_lat));
      checkOutput($sformatf("v%0d_hi", i), 32'(hi), 32'(vecs[i].exp_hi));
      checkOutput($sformatf("v%0d_lo", i), 32'(lo), 32'(vecs[i].exp_lo));
      checkOutput($sformatf("v%0d_divzero", i), 32'(divzero), 32'(vecs[i].exp_dz));
      checkOutput($sformatf("v%0d_wehilo", i), 32'(wehilo), 32'd1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // A start while busy is ignored. A start during FIN is ignored too.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h1234;
    b     = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'h0005;
    b     = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("busy_ign_done",    32'(done_seen), 32'd1);
    checkOutput("busy_ign_hi",      32'(hi),        32'h0001);
    checkOutput("busy_ign_lo",      32'(lo),        32'h2340);
    checkOutput("busy_ign_divzero", 32'(divzero),   32'd0);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'h00AB;
    b     = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("fin_ign_busy",    32'(busy),    32'd0);
    checkOutput("fin_ign_done",    32'(done),    32'd0);
    checkOutput("fin_ign_divzero", 32'(divzero), 32'd0);
    checkOutput("fin_ign_lo",      32'(lo),      32'h2340);

    // Reset at iteration 8 aborts the multiply: hi/lo clear, no done pulse.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("abort_hi",   32'(hi),   32'd0);
    checkOutput("abort_lo",   32'(lo),   32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);

    // A fresh start after reset runs normally.
    applyStimulus(1'b0, 16'h1234, 16'h0010, lat, stc);
    checkOutput("post_reset_latency", 32'(lat), 32'(mulLatency(16'h0010)));
    checkOutput("post_reset_hi",      32'(hi),  32'h0001);
    checkOutput("post_reset_lo",      32'(lo),  32'h2340);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
